// File: rtl/reimu_pkg.sv
// rtl/reimu_pkg.sv - shared player/playfield constants, state enum and clamp helper
package reimu_pkg;

    localparam logic [3:0] BTN_UP    = 4'b0000;
    localparam logic [3:0] BTN_LEFT  = 4'b0001;
    localparam logic [3:0] BTN_DOWN  = 4'b0010;
    localparam logic [3:0] BTN_RIGHT = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_DYING,
        ST_GAMEOVER
    } state_e;

    localparam logic [9:0] X_MIN     = 10'd0;
    localparam logic [9:0] X_MAX     = 10'd440;
    localparam logic [9:0] Y_MIN     = 10'd0;
    localparam logic [9:0] Y_MAX     = 10'd460;
    localparam logic [9:0] X_START   = 10'd220;
    localparam logic [9:0] Y_START   = 10'd360;
    localparam logic [2:0] LIVES     = 3'd3;
    localparam logic [9:0] FAST_STEP = 10'd2;
    localparam logic [9:0] SLOW_STEP = 10'd1;
    localparam logic [7:0] RESPAWN_TICKS = 8'd60;
    localparam logic [7:0] INVULN_TICKS  = 8'd120;

    // 11-bit arithmetic so a decrement near zero saturates instead of wrapping.
    function automatic logic [9:0] clamp_step(input logic [9:0] pos, input logic [9:0] step,
                                              input logic dec, input logic [9:0] lo,
                                              input logic [9:0] hi);
        logic [10:0] p;
        logic [10:0] s;
        logic [9:0]  r;
        p = {1'b0, pos};
        s = {1'b0, step};
        if (dec) begin
            r = (p < ({1'b0, lo} + s)) ? lo : pos - step;
        end else begin
            r = ((p + s) > {1'b0, hi}) ? hi : pos + step;
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_down_counter.sv
// rtl/tick_down_counter.sv - loadable down counter with enable-gated decrement and zero flag
module tick_down_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         zero_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/reimu_ctrl.sv
// rtl/reimu_ctrl.sv - player-ship sequencer: movement, lives, respawn and invulnerability
module reimu_ctrl
    import reimu_pkg::*;
(
    input  logic       clk22,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       start,
    input  logic [3:0] btnstate,
    input  logic       focus,
    input  logic       hit,
    output logic [9:0] reimux,
    output logic [9:0] reimuy,
    output logic [2:0] lives,
    output logic       invuln,
    output logic       visible,
    output logic       gameover
);

    state_e     state_q;
    logic       hit_pend_q;
    logic [2:0] lives_q;
    logic [9:0] x_q;
    logic [9:0] y_q;
    logic       visible_q;
    logic       gameover_q;

    logic [7:0] resp_cnt;
    logic       resp_zero;
    logic [7:0] inv_cnt_unused;
    logic       inv_zero;
    logic       hit_now;
    logic       take_hit;
    logic       respawn;
    logic [9:0] step;

    // A hit arriving on the tick cycle itself is consumed by that tick.
    assign hit_now  = hit_pend_q | hit;
    assign take_hit = tick && (state_q == ST_PLAY) && hit_now && inv_zero;
    assign respawn  = tick && (state_q == ST_DYING) && (resp_cnt == 8'd1);
    assign step     = focus ? SLOW_STEP : FAST_STEP;

    tick_down_counter #(.W(8)) u_respawn_cnt (
        .clk_i      (clk22),
        .rst_ni     (rst_n),
        .load_i     (take_hit && (lives_q != 3'd1)),
        .load_val_i (RESPAWN_TICKS),
        .en_i       (tick && (state_q == ST_DYING)),
        .count_o    (resp_cnt),
        .zero_o     (resp_zero)
    );

    tick_down_counter #(.W(8)) u_invuln_cnt (
        .clk_i      (clk22),
        .rst_ni     (rst_n),
        .load_i     (respawn),
        .load_val_i (INVULN_TICKS),
        .en_i       (tick),
        .count_o    (inv_cnt_unused),
        .zero_o     (inv_zero)
    );

    always_ff @(posedge clk22 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hit_pend_q <= 1'b0;
            lives_q    <= LIVES;
            x_q        <= X_START;
            y_q        <= Y_START;
            visible_q  <= 1'b1;
            gameover_q <= 1'b0;
        end else begin
            hit_pend_q <= tick ? 1'b0 : (hit_pend_q | (hit && (state_q == ST_PLAY)));
            if (tick) begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) state_q <= ST_PLAY;
                    end
                    ST_PLAY: begin
                        if (take_hit) begin
                            lives_q   <= lives_q - 3'd1;
                            visible_q <= 1'b0;
                            if (lives_q == 3'd1) begin
                                state_q    <= ST_GAMEOVER;
                                gameover_q <= 1'b1;
                                x_q        <= 10'd0;
                                y_q        <= 10'd0;
                            end else begin
                                state_q <= ST_DYING;
                            end
                        end else begin
                            case (btnstate)
                                BTN_UP:    y_q <= clamp_step(y_q, step, 1'b1, Y_MIN, Y_MAX);
                                BTN_LEFT:  x_q <= clamp_step(x_q, step, 1'b1, X_MIN, X_MAX);
                                BTN_DOWN:  y_q <= clamp_step(y_q, step, 1'b0, Y_MIN, Y_MAX);
                                BTN_RIGHT: x_q <= clamp_step(x_q, step, 1'b0, X_MIN, X_MAX);
                                default: ;
                            endcase
                        end
                    end
                    ST_DYING: begin
                        if (!resp_zero && (resp_cnt == 8'd1)) begin
                            state_q   <= ST_PLAY;
                            x_q       <= X_START;
                            y_q       <= Y_START;
                            visible_q <= 1'b1;
                        end
                    end
                    ST_GAMEOVER: begin
                        if (start) begin
                            state_q    <= ST_IDLE;
                            lives_q    <= LIVES;
                            x_q        <= X_START;
                            y_q        <= Y_START;
                            visible_q  <= 1'b1;
                            gameover_q <= 1'b0;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign reimux   = x_q;
    assign reimuy   = y_q;
    assign lives    = lives_q;
    assign invuln   = !inv_zero;
    assign visible  = visible_q;
    assign gameover = gameover_q;

endmodule

// File: tb/tb_reimu_ctrl.sv
// tb/tb_reimu_ctrl.sv - randomized and directed bench for reimu_ctrl against a behavioural player model
module tb_reimu_ctrl;

    localparam int M_IDLE = 0, M_PLAY = 1, M_DYING = 2, M_OVER = 3;

    logic       clk22 = 1'b0;
    logic       rst_n, tick, start, focus, hit;
    logic [3:0] btnstate;
    logic [9:0] reimux, reimuy;
    logic [2:0] lives;
    logic       invuln, visible, gameover;

    int checks = 0;
    int failures = 0;

    int m_mode, m_x, m_y, m_lives, m_dying, m_inv;
    bit m_pend;

    always #5 clk22 = ~clk22;

    reimu_ctrl dut (
        .clk22    (clk22),
        .rst_n    (rst_n),
        .tick     (tick),
        .start    (start),
        .btnstate (btnstate),
        .focus    (focus),
        .hit      (hit),
        .reimux   (reimux),
        .reimuy   (reimuy),
        .lives    (lives),
        .invuln   (invuln),
        .visible  (visible),
        .gameover (gameover)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_x = 220; m_y = 360; m_lives = 3;
        m_dying = 0; m_inv = 0; m_pend = 0;
    endtask

    task automatic model_step(input bit t, input bit s, input int b, input bit f, input bit h);
        int inv_old;
        int st;
        if (m_mode == M_PLAY && h) m_pend = 1;
        if (t) begin
            inv_old = m_inv;
            if (m_inv > 0) m_inv--;
            st = f ? 1 : 2;
            case (m_mode)
                M_IDLE: if (s) m_mode = M_PLAY;
                M_PLAY: begin
                    if (m_pend && inv_old == 0) begin
                        m_lives--;
                        if (m_lives == 0) begin
                            m_mode = M_OVER; m_x = 0; m_y = 0;
                        end else begin
                            m_mode = M_DYING; m_dying = 60;
                        end
                    end else begin
                        case (b)
                            0: m_y = clampi(m_y - st, 0, 460);
                            1: m_x = clampi(m_x - st, 0, 440);
                            2: m_y = clampi(m_y + st, 0, 460);
                            3: m_x = clampi(m_x + st, 0, 440);
                            default: ;
                        endcase
                    end
                end
                M_DYING: begin
                    if (m_dying == 1) begin
                        m_mode = M_PLAY; m_x = 220; m_y = 360; m_inv = 120;
                    end
                    m_dying--;
                end
                default: if (s) begin
                    m_mode = M_IDLE; m_lives = 3; m_x = 220; m_y = 360;
                end
            endcase
            m_pend = 0;
        end
    endtask

    task automatic compare_all();
        check("reimux", 32'(reimux), m_x);
        check("reimuy", 32'(reimuy), m_y);
        check("lives", 32'(lives), m_lives);
        check("invuln", 32'(invuln), (m_inv > 0) ? 1 : 0);
        check("visible", 32'(visible), (m_mode == M_IDLE || m_mode == M_PLAY) ? 1 : 0);
        check("gameover", 32'(gameover), (m_mode == M_OVER) ? 1 : 0);
    endtask

    task automatic cycle(input bit t, input bit s, input logic [3:0] b, input bit f, input bit h);
        @(negedge clk22);
        tick = t; start = s; btnstate = b; focus = f; hit = h;
        @(posedge clk22);
        #1;
        model_step(t, s, int'(b), f, h);
        compare_all();
    endtask

    task automatic ticks(input int n, input bit s, input logic [3:0] b, input bit f);
        for (int i = 0; i < n; i++) cycle(1'b1, s, b, f, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; start = 1'b0; btnstate = 4'hF; focus = 1'b0; hit = 1'b0;
        model_reset();
        repeat (2) @(posedge clk22);
        #1;
        compare_all();
        @(negedge clk22);
        rst_n = 1'b1;

        cycle(1'b0, 1'b1, 4'h3, 1'b0, 1'b0);
        check("idle_no_tick_x", 32'(reimux), 220);
        cycle(1'b1, 1'b1, 4'hF, 1'b0, 1'b0);
        ticks(1, 1'b1, 4'hF, 1'b0);

        ticks(200, 1'b0, 4'h3, 1'b0);
        check("sat_right", 32'(reimux), 440);
        ticks(450, 1'b0, 4'h1, 1'b1);
        check("sat_left", 32'(reimux), 0);
        ticks(300, 1'b0, 4'h2, 1'b0);
        check("sat_down", 32'(reimuy), 460);

        cycle(1'b0, 1'b0, 4'hF, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
        check("hit_lives", 32'(lives), 2);
        check("hit_visible", 32'(visible), 0);
        ticks(59, 1'b0, 4'h3, 1'b0);
        check("dying_hidden", 32'(visible), 0);
        ticks(1, 1'b0, 4'hF, 1'b0);
        check("respawn_x", 32'(reimux), 220);
        check("respawn_invuln", 32'(invuln), 1);
        cycle(1'b0, 1'b0, 4'hF, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
        check("invuln_hit_lives", 32'(lives), 2);
        ticks(118, 1'b0, 4'hF, 1'b0);
        check("invuln_last", 32'(invuln), 1);
        ticks(1, 1'b0, 4'hF, 1'b0);
        check("invuln_over", 32'(invuln), 0);

        cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
        check("hit_beats_move_y", 32'(reimuy), 360);
        check("hit_beats_move_lives", 32'(lives), 1);
        ticks(60, 1'b0, 4'hF, 1'b0);
        ticks(120, 1'b0, 4'hF, 1'b0);
        cycle(1'b0, 1'b0, 4'hF, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
        check("gameover_flag", 32'(gameover), 1);
        check("gameover_y", 32'(reimuy), 0);
        ticks(1, 1'b1, 4'hF, 1'b0);
        check("restart_lives", 32'(lives), 3);
        ticks(2, 1'b1, 4'hF, 1'b0);

        cycle(1'b0, 1'b0, 4'hF, 1'b0, 1'b1);
        ticks(11, 1'b0, 4'h3, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("async_reset_visible", 32'(visible), 1);
        @(negedge clk22);
        rst_n = 1'b1;

        for (int i = 0; i < 6000; i++) begin
            logic [3:0] b;
            b = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            cycle($urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0, b,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 59) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
